// File: rtl/shift_register_sched_pkg.sv
// Shared types and constants for the shift-register command sequencer.
package shift_register_sched_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Shift direction encoding as seen by the datapath
    localparam logic DIR_LEFT  = 1'b0;  // din enters LSB
    localparam logic DIR_RIGHT = 1'b1;  // din enters MSB

    // Requester identifiers
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/shift_register_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie;
// after every accepted grant it moves to the requester that was not granted.
module rr_arb2
    import shift_register_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id,
    output logic rr_ptr
);

    logic ptr_reg;

    // Grant the only requester, or the pointed-to one when both request
    always_comb begin
        gnt0   = req0 && (!req1 || (ptr_reg == REQ_ID0));
        gnt1   = req1 && (!req0 || (ptr_reg == REQ_ID1));
        gnt_id = gnt1 ? REQ_ID1 : REQ_ID0;
    end

    // Pointer moves to the loser of the accepted grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= REQ_ID0;
        end else if (advance) begin
            ptr_reg <= ~gnt_id;
        end
    end

    assign rr_ptr = ptr_reg;

endmodule

// File: rtl/shift_register_sched.sv
// Command sequencer: arbitrates two requesters, serialises the granted word into
// the external shift register, then samples its parallel output and checks it.
module shift_register_sched
    import shift_register_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    output logic             req1_ready,
    output logic             sr_en,
    output logic             sr_dir,
    output logic             sr_din,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic             dir_reg;
    logic             id_reg;
    logic             done_reg;
    logic             done_id_reg;
    logic [WIDTH-1:0] result_reg;
    logic             err_reg;

    logic             idle;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_id;
    logic             accept;
    logic             rr_ptr_unused;
    logic [WIDTH-1:0] ordered;
    logic             last_bit;

    assign idle = (state_reg == ST_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0_valid && idle),
        .req1    (req1_valid && idle),
        .advance (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id),
        .rr_ptr  (rr_ptr_unused)
    );

    // Any grant in IDLE is a transfer: grants only exist for valid requesters
    assign accept     = gnt0 || gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign busy       = !idle;

    // Word rearranged into transmit order: element i is the bit sent when cnt == i
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            assign ordered[gi] = (dir_reg == DIR_RIGHT) ? data_reg[gi] : data_reg[WIDTH-1-gi];
        end
    endgenerate

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Datapath drive decoded from registered state only; quiet outside SHIFT
    always_comb begin
        sr_en  = 1'b0;
        sr_dir = 1'b0;
        sr_din = 1'b0;
        if (state_reg == ST_SHIFT) begin
            sr_en  = 1'b1;
            sr_dir = dir_reg;
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_reg == CW'(i)) begin
                    sr_din = ordered[i];
                end
            end
        end
    end

    // Sequencer FSM with registered completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            data_reg    <= '0;
            dir_reg     <= 1'b0;
            id_reg      <= 1'b0;
            done_reg    <= 1'b0;
            done_id_reg <= 1'b0;
            result_reg  <= '0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        data_reg  <= gnt1 ? req1_data : req0_data;
                        dir_reg   <= gnt1 ? req1_dir : req0_dir;
                        id_reg    <= gnt_id;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Datapath was loaded at the end of the last SHIFT cycle
                    result_reg  <= sr_q;
                    err_reg     <= (sr_q != data_reg);
                    done_id_reg <= id_reg;
                    done_reg    <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign result  = result_reg;
    assign err     = err_reg;

endmodule
